// File: rtl/uart_sol.sv
// uart_sol: full-duplex 8N1 UART, independent TX and RX sharing one clock.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   en        in   transmit request, sampled only while rdy=1
//   data_in   in   byte to transmit, captured with en
//   rdy       out  transmitter idle, ready for a byte
//   dout      out  serial TX line, idle high
//   din       in   serial RX line (asynchronous), idle high
//   valid     out  one-cycle strobe, data_out holds a new byte
//   data_out  out  last correctly received byte
module uart_sol #(
    parameter int unsigned FREQ         = 32_000_000,
    parameter int unsigned BAUD_RATE    = 9600,
    parameter int unsigned CLKS_PER_BIT = FREQ / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] data_in,
    output logic       rdy,
    output logic       dout,
    input  logic       din,
    output logic       valid,
    output logic [7:0] data_out
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);

    // ---------------------------------------------------------------- transmitter
    typedef enum logic [1:0] {StTxIdle, StTxStart, StTxData, StTxStop} tx_state_e;

    tx_state_e     r_tx_state, w_tx_state_d;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_idx;
    logic [7:0]    r_tx_shift;
    logic          w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == BitLast);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= StTxIdle;
        end else begin
            r_tx_state <= w_tx_state_d;
        end
    end

    always_comb begin
        w_tx_state_d = r_tx_state;
        unique case (r_tx_state)
            StTxIdle:  if (en) w_tx_state_d = StTxStart;
            StTxStart: if (w_tx_bit_end) w_tx_state_d = StTxData;
            StTxData:  if (w_tx_bit_end && (r_tx_idx == 3'd7)) w_tx_state_d = StTxStop;
            StTxStop:  if (w_tx_bit_end) w_tx_state_d = StTxIdle;
            default:   w_tx_state_d = StTxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
        end else if (r_tx_state == StTxIdle) begin
            r_tx_cnt <= '0;
            if (en) begin
                r_tx_shift <= data_in;
                r_tx_idx   <= '0;
            end
        end else if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_state == StTxData) r_tx_idx <= r_tx_idx + 3'd1;
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    always_comb begin
        rdy  = (r_tx_state == StTxIdle);
        dout = 1'b1;
        unique case (r_tx_state)
            StTxStart: dout = 1'b0;
            StTxData:  dout = r_tx_shift[r_tx_idx];
            default:   dout = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- receiver
    typedef enum logic [1:0] {StRxIdle, StRxStart, StRxData, StRxStop} rx_state_e;

    rx_state_e     r_rx_state, w_rx_state_d;
    logic [1:0]    r_rx_sync;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_idx;
    logic [7:0]    r_rx_shift;
    logic          r_rx_wait_high;
    logic          r_valid;
    logic [7:0]    r_data_out;
    logic          w_rx;
    logic          w_rx_half;
    logic          w_rx_bit_end;
    logic          w_rx_done;
    logic          w_rx_frame_err;

    assign w_rx         = r_rx_sync[1];
    assign w_rx_half    = (r_rx_cnt == HalfLast);
    assign w_rx_bit_end = (r_rx_cnt == BitLast);

    // Reset to idle-high so reset release is not seen as a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], din};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= StRxIdle;
        end else begin
            r_rx_state <= w_rx_state_d;
        end
    end

    always_comb begin
        w_rx_state_d = r_rx_state;
        unique case (r_rx_state)
            StRxIdle:  if (!w_rx && !r_rx_wait_high) w_rx_state_d = StRxStart;
            StRxStart: if (w_rx_half) w_rx_state_d = w_rx ? StRxIdle : StRxData;
            StRxData:  if (w_rx_bit_end && (r_rx_idx == 3'd7)) w_rx_state_d = StRxStop;
            StRxStop:  if (w_rx_bit_end) w_rx_state_d = StRxIdle;
            default:   w_rx_state_d = StRxIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
        end else begin
            unique case (r_rx_state)
                StRxIdle: begin
                    r_rx_cnt <= '0;
                    r_rx_idx <= '0;
                end
                StRxStart: r_rx_cnt <= w_rx_half ? '0 : r_rx_cnt + 1'b1;
                StRxData: begin
                    if (w_rx_bit_end) begin
                        r_rx_cnt   <= '0;
                        r_rx_idx   <= r_rx_idx + 3'd1;
                        r_rx_shift <= {w_rx, r_rx_shift[7:1]};
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                StRxStop: r_rx_cnt <= w_rx_bit_end ? '0 : r_rx_cnt + 1'b1;
                default:  r_rx_cnt <= '0;
            endcase
        end
    end

    // After a framing error the line may still be low; block start detection
    // until it has been seen high again.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_wait_high <= 1'b0;
            r_valid        <= 1'b0;
            r_data_out     <= '0;
        end else begin
            r_valid <= w_rx_done;
            if (w_rx_done) r_data_out <= r_rx_shift;
            if (w_rx_frame_err) begin
                r_rx_wait_high <= 1'b1;
            end else if (w_rx) begin
                r_rx_wait_high <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rx_done      = (r_rx_state == StRxStop) && w_rx_bit_end && w_rx;
        w_rx_frame_err = (r_rx_state == StRxStop) && w_rx_bit_end && !w_rx;
        valid          = r_valid;
        data_out       = r_data_out;
    end

endmodule

// File: tb/tb_uart_sol.sv
// tb_uart_sol: directed self-checking bench for uart_sol at 16 clocks per bit.
module tb_uart_sol;

    localparam int unsigned Cpb = 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] data_in;
    logic       rdy;
    logic       dout;
    logic       din_drv;
    logic       loop_en;
    logic       w_din;
    logic       valid;
    logic [7:0] data_out;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cyc;
    int unsigned vcnt;
    int unsigned vcyc;
    int unsigned rx_start_cyc;
    logic [7:0]  vq[$];

    assign w_din = loop_en ? dout : din_drv;

    uart_sol #(
        .FREQ        (32_000_000),
        .BAUD_RATE   (9600),
        .CLKS_PER_BIT(Cpb)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .data_in (data_in),
        .rdy     (rdy),
        .dout    (dout),
        .din     (w_din),
        .valid   (valid),
        .data_out(data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Valid monitor: a pulse wider than one cycle is counted more than once.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid === 1'b1) begin
            vcnt = vcnt + 1;
            vcyc = cyc;
            vq.push_back(data_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one frame on din; called and returns on a falling clock edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            din_drv = f[i];
            if (i == 0) rx_start_cyc = cyc;
            repeat (Cpb) @(negedge clk);
        end
        din_drv = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int unsigned base;
        int unsigned lat;
        int unsigned rdy_low;
        logic        ok;
        logic [9:0]  tx_frame;
        logic [7:0]  lb_bytes [3];
        int unsigned budget;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        vcnt     = 0;
        vcyc     = 0;
        loop_en  = 1'b0;
        en       = 1'b0;
        data_in  = 8'h00;
        din_drv  = 1'b1;
        rst      = 1'b0;

        // Reset with random activity on inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            en      = 1'($urandom);
            din_drv = 1'($urandom);
        end
        check("rst_dout", dout, 1'b1);
        check("rst_rdy", rdy, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_data_out", data_out, 8'h00);
        en      = 1'b0;
        din_drv = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // TX 8'hA5 with a one-cycle en pulse; a second en mid-frame is ignored
        tx_frame = {1'b1, 8'hA5, 1'b0};
        rdy_low  = 0;
        data_in  = 8'hA5;
        en       = 1'b1;
        @(negedge clk);
        en      = 1'b0;
        data_in = 8'h00;
        for (int b = 0; b < 10; b++) begin
            ok = 1'b1;
            for (int c = 0; c < Cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (b == 2 && c == 8) en = 1'b1;
                if (b == 2 && c == 9) en = 1'b0;
                if (dout !== tx_frame[b]) ok = 1'b0;
                if (rdy === 1'b0) rdy_low++;
            end
            check($sformatf("tx_bit%0d", b), ok, 1'b1);
        end
        check("tx_rdy_low_cycles", rdy_low, 10 * Cpb);
        @(negedge clk);
        check("tx_rdy_back", rdy, 1'b1);
        check("tx_dout_idle", dout, 1'b1);
        repeat (20) @(negedge clk);
        check("tx_no_second_frame", {rdy, dout}, 2'b11);

        // RX 8'h3C with latency and single-pulse check
        base = vcnt;
        send_frame(8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        check("rx_3c_count", vcnt - base, 1);
        check("rx_3c_data", data_out, 8'h3C);
        lat = vcyc - rx_start_cyc;
        check("rx_latency_in_range", (lat >= 154 && lat <= 156), 1'b1);

        // Framing error: stop bit 0, data_out must keep 8'h3C
        base = vcnt;
        send_frame(8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        check("rx_frame_err_no_valid", vcnt - base, 0);
        check("rx_frame_err_keep", data_out, 8'h3C);

        // Glitch: 4 clocks low then high, then a good frame
        base    = vcnt;
        din_drv = 1'b0;
        repeat (4) @(negedge clk);
        din_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("rx_glitch_no_valid", vcnt - base, 0);
        send_frame(8'h55, 1'b1);
        repeat (40) @(negedge clk);
        check("rx_55_count", vcnt - base, 1);
        check("rx_55_data", data_out, 8'h55);

        // Back-to-back RX frames without idle gap
        base = vcnt;
        send_frame(8'h81, 1'b1);
        send_frame(8'h7E, 1'b1);
        repeat (40) @(negedge clk);
        check("rx_b2b_count", vcnt - base, 2);
        check("rx_b2b_last", data_out, 8'h7E);

        // Loopback: three bytes back-to-back on rdy
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h67;
        vq.delete();
        base    = vcnt;
        loop_en = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            budget = 0;
            while (rdy !== 1'b1 && budget < 500) begin
                @(negedge clk);
                budget++;
            end
            check($sformatf("lb_rdy_wait%0d", k), (budget < 500), 1'b1);
            data_in = lb_bytes[k];
            en      = 1'b1;
            @(negedge clk);
            en = 1'b0;
        end
        budget = 0;
        while (vcnt - base < 3 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        repeat (40) @(negedge clk);
        check("lb_count", vcnt - base, 3);
        for (int k = 0; k < 3; k++) begin
            if (k < vq.size()) begin
                check($sformatf("lb_byte%0d", k), vq[k], lb_bytes[k]);
            end else begin
                check($sformatf("lb_byte%0d_missing", k), vq.size(), 3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
